// File: rtl/region_switch_ctrl_pkg.sv
// Shared encodings for the region switch controller: forced-region modes,
// controller states and region line levels.
package region_pkg;

   typedef enum logic [1:0] {
      MODE_AUTO = 2'd0,
      MODE_NTSC = 2'd1,
      MODE_PAL  = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PRESS = 2'd2,
      PULSE = 2'd3
   } state_t;

   localparam logic NTSC = 1'b0;
   localparam logic PAL  = 1'b1;

   // Short press with the override window open steps AUTO -> NTSC -> PAL -> AUTO.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_AUTO: return MODE_NTSC;
         MODE_NTSC: return MODE_PAL;
         default:   return MODE_AUTO;
      endcase
   endfunction

   function automatic logic region_sel(input mode_t m, input logic cic_region);
      case (m)
         MODE_NTSC: return NTSC;
         MODE_PAL:  return PAL;
         default:   return cic_region;
      endcase
   endfunction

endpackage

// File: rtl/region_switch_ctrl_if.sv
// CIC status inputs and console-facing outputs of the region switch controller.
// The controller side is the slave; the CIC stage / environment is the master.
interface region_switch_ctrl_if;

   logic       cic_start;
   logic       cic_region;
   logic       cic_rst_host;
   logic       region_override;
   logic       region_out;
   logic [1:0] mode;
   logic       rst_host_out;
   logic       led_ntsc;
   logic       led_pal;

   modport master (
      output cic_start, cic_region, cic_rst_host, region_override,
      input  region_out, mode, rst_host_out, led_ntsc, led_pal
   );

   modport slave (
      input  cic_start, cic_region, cic_rst_host, region_override,
      output region_out, mode, rst_host_out, led_ntsc, led_pal
   );

endinterface

// File: rtl/region_switch_ctrl_btn_debounce.sv
// Front-panel button conditioning: two-flop synchroniser, then a level that only
// moves after DEBOUNCE_TICKS consecutive samples disagreeing with it.
module btn_debounce #(
   parameter int DEBOUNCE_TICKS = 20_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic btn,
   output logic btn_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             btn_p0;
   logic             btn_p1;
   logic [CNT_W-1:0] stable_cnt;

   // stage p0/p1: synchroniser, inverted to active-high; then the stability counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_p0     <= 1'b0;
         btn_p1     <= 1'b0;
         btn        <= 1'b0;
         btn_rise   <= 1'b0;
         stable_cnt <= '0;
      end else begin
         btn_p0   <= ~btn_n;
         btn_p1   <= btn_p0;
         btn_rise <= 1'b0;
         if (btn_p1 == btn) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            stable_cnt <= '0;
            btn        <= btn_p1;
            btn_rise   <= btn_p1;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/region_switch_ctrl.sv
// Region selection and host-reset sequencer sitting after the dual-CIC lockout:
// forced-region mode via the front-panel button, timed host resets, status LEDs.
module region_switch_ctrl
   import region_pkg::*;
#(
   parameter int DEBOUNCE_TICKS    = 20_000,
   parameter int LONG_PRESS_TICKS  = 4_000_000,
   parameter int RESET_PULSE_TICKS = 400_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_n,
   region_switch_ctrl_if.slave bus
);

   localparam int HOLD_W  = $clog2(LONG_PRESS_TICKS + 1);
   localparam int PULSE_W = $clog2(RESET_PULSE_TICKS + 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LONG_PRESS_TICKS);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_PRESS_TICKS - 1);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_TICKS - 1);

   state_t               state;
   state_t               state_nx;
   mode_t                mode_q;
   mode_t                mode_nx;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [HOLD_W-1:0]    hold_nx;
   logic [PULSE_W-1:0]   pulse_cnt;
   logic [PULSE_W-1:0]   pulse_nx;
   logic                 btn;
   logic                 btn_rise;
   logic                 region;

   btn_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
   ) u_btn_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn_n    (btn_n),
      .btn      (btn),
      .btn_rise (btn_rise)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mode_q    <= MODE_AUTO;
         hold_cnt  <= '0;
         pulse_cnt <= '0;
      end else begin
         state     <= state_nx;
         mode_q    <= mode_nx;
         hold_cnt  <= hold_nx;
         pulse_cnt <= pulse_nx;
      end
   end

   always_comb begin
      state_nx = state;
      mode_nx  = mode_q;
      hold_nx  = hold_cnt;
      pulse_nx = pulse_cnt;
      case (state)
         IDLE: begin
            if (bus.cic_start && !bus.cic_rst_host) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (bus.cic_rst_host) begin
               state_nx = IDLE;
            end else if (btn_rise) begin
               state_nx = PRESS;
               hold_nx  = '0;
            end
         end
         PRESS: begin
            // a CIC reset request wins over any release or long-press decision
            if (bus.cic_rst_host) begin
               state_nx = IDLE;
               hold_nx  = '0;
            end else if (!btn) begin
               if (bus.region_override) begin
                  mode_nx = next_mode(mode_q);
               end
               state_nx = PULSE;
               pulse_nx = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               mode_nx  = MODE_AUTO;
               state_nx = PULSE;
               pulse_nx = '0;
               hold_nx  = HOLD_MAX;
            end else begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         PULSE: begin
            if (pulse_cnt == PULSE_LAST) begin
               state_nx = IDLE;
               pulse_nx = '0;
            end else begin
               pulse_nx = pulse_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign region = (state == IDLE) ? NTSC : region_sel(mode_q, bus.cic_region);

   assign bus.region_out = region;
   assign bus.mode       = mode_q;
   assign bus.led_ntsc   = (state != IDLE) && !region;
   assign bus.led_pal    = (state != IDLE) && region;
   // gated by rst so the console sees no reset request while the controller itself is held in reset
   assign bus.rst_host_out = rst && (bus.cic_rst_host || (state == PULSE));

endmodule

// File: tb/tb_region_switch_ctrl.sv
// Bench for region_switch_ctrl: directed steps plus randomized presses checked
// against an outcome-level model of mode, region and reset pulses.
`timescale 1ns/1ps
module tb_region_switch_ctrl;

   localparam int DEB  = 4;
   localparam int LONG = 50;
   localparam int PLS  = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   m_mode = 0;

   region_switch_ctrl_if bus();

   region_switch_ctrl #(
      .DEBOUNCE_TICKS    (DEB),
      .LONG_PRESS_TICKS  (LONG),
      .RESET_PULSE_TICKS (PLS)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n),
      .bus   (bus)
   );

   always #125 clk = ~clk;

   function automatic int ref_region(input int m, input logic cr);
      if (m == 1) return 0;
      if (m == 2) return 1;
      return int'(cr);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Holds the button for 'hold' cycles, then watches 'tail' more cycles.
   task automatic do_press(input int hold, input int tail, output int npulses, output int plen,
                           output int pmode, output int preg, output int idle_ok);
      logic prev;
      int   cur;
      npulses = 0; plen = 0; pmode = -1; preg = -1; idle_ok = 0; prev = 1'b0; cur = 0;
      for (int c = 0; c < hold + tail; c++) begin
         @(negedge clk);
         if (bus.rst_host_out && !prev) begin
            npulses++;
            cur   = 1;
            pmode = int'(bus.mode);
            preg  = int'(bus.region_out);
         end else if (bus.rst_host_out) begin
            cur++;
         end else if (prev) begin
            plen    = cur;
            idle_ok = (bus.region_out == 1'b0 && bus.led_ntsc == 1'b0 && bus.led_pal == 1'b0) ? 1 : 0;
         end
         prev  = bus.rst_host_out;
         btn_n = (c < hold) ? 1'b0 : 1'b1;
      end
      btn_n = 1'b1;
   endtask

   task automatic press_and_check(input string tag, input int hold, input int exp_mode);
      int np, pl, pm, pr, io;
      do_press(hold, 45, np, pl, pm, pr, io);
      chk({tag, "_npulse"}, np, 1);
      chk({tag, "_plen"}, pl, PLS);
      chk({tag, "_pmode"}, pm, exp_mode);
      chk({tag, "_preg"}, pr, ref_region(exp_mode, bus.cic_region));
      chk({tag, "_idle"}, io, 1);
      chk({tag, "_run_reg"}, bus.region_out, ref_region(exp_mode, bus.cic_region));
      chk({tag, "_led_pal"}, bus.led_pal, ref_region(exp_mode, bus.cic_region));
      chk({tag, "_led_ntsc"}, bus.led_ntsc, 1 - ref_region(exp_mode, bus.cic_region));
      m_mode = exp_mode;
   endtask

   initial begin
      int np, pl, pm, pr, io, errs, hold, exp_mode, seen;
      logic ovr, lng;

      bus.cic_start = 1'b0;
      bus.cic_region = 1'b1;
      bus.cic_rst_host = 1'b1;
      bus.region_override = 1'b0;
      step(3);
      chk("rst_region", bus.region_out, 0);
      chk("rst_mode", bus.mode, 0);
      chk("rst_host", bus.rst_host_out, 0);
      chk("rst_led_ntsc", bus.led_ntsc, 0);
      chk("rst_led_pal", bus.led_pal, 0);
      bus.cic_rst_host = 1'b0;
      rst = 1'b1;
      step(3);
      chk("idle_wait_region", bus.region_out, 0);
      chk("idle_wait_led", bus.led_pal, 0);
      bus.cic_start = 1'b1;
      step(1);
      chk("run_region", bus.region_out, 1);
      chk("run_led_pal", bus.led_pal, 1);
      chk("run_led_ntsc", bus.led_ntsc, 0);
      chk("run_mode", bus.mode, 0);

      // short presses with the override window open cycle the mode
      bus.region_override = 1'b1;
      for (int i = 0; i < 3; i++) begin
         press_and_check($sformatf("ovr%0d", i), 20, (m_mode + 1) % 3);
      end

      bus.region_override = 1'b0;
      press_and_check("no_ovr", 20, m_mode);

      // reach PAL, then a long hold that outlasts the pulse
      bus.region_override = 1'b1;
      while (m_mode != 2) press_and_check("to_pal", 15, (m_mode + 1) % 3);
      press_and_check("long_hold", 100, 0);

      for (int i = 0; i < 3; i++) begin
         do_press(3, 20, np, pl, pm, pr, io);
         chk($sformatf("glitch%0d_npulse", i), np, 0);
         chk($sformatf("glitch%0d_mode", i), bus.mode, m_mode);
      end

      for (int i = 0; i < 10; i++) begin
         ovr = 1'($urandom_range(0, 1));
         lng = ($urandom_range(0, 3) == 0);
         bus.cic_region = 1'($urandom_range(0, 1));
         bus.region_override = ovr;
         step(2);
         chk($sformatf("rnd%0d_pre_reg", i), bus.region_out, ref_region(m_mode, bus.cic_region));
         hold = lng ? int'($urandom_range(60, 90)) : int'($urandom_range(8, 40));
         exp_mode = lng ? 0 : (ovr ? (m_mode + 1) % 3 : m_mode);
         press_and_check($sformatf("rnd%0d", i), hold, exp_mode);
      end

      // CIC reset request arriving at the release wins: no mode change, no pulse
      bus.region_override = 1'b1;
      repeat (20) begin
         @(negedge clk);
         btn_n = 1'b0;
      end
      @(negedge clk);
      btn_n = 1'b1;
      bus.cic_rst_host = 1'b1;
      errs = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.rst_host_out !== 1'b1) errs++;
      end
      chk("cicrst_follow", errs, 0);
      chk("cicrst_idle_reg", bus.region_out, 0);
      chk("cicrst_mode", bus.mode, m_mode);
      bus.cic_rst_host = 1'b0;
      #1;
      chk("cicrst_drop", bus.rst_host_out, 0);
      errs = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.rst_host_out !== 1'b0) errs++;
      end
      chk("cicrst_no_pulse", errs, 0);
      chk("cicrst_mode_kept", bus.mode, m_mode);
      chk("cicrst_run_reg", bus.region_out, ref_region(m_mode, bus.cic_region));

      // asynchronous reset in the middle of a pulse
      if (m_mode == 2) press_and_check("pre_arst", 15, 0);
      repeat (20) begin
         @(negedge clk);
         btn_n = 1'b0;
      end
      @(negedge clk);
      btn_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         @(negedge clk);
         if (bus.rst_host_out === 1'b1) seen = 1;
      end
      chk("arst_pulse_seen", seen, 1);
      chk("arst_pulse_mode", bus.mode, m_mode + 1);
      step(3);
      #30 rst = 1'b0;
      #1;
      chk("arst_host", bus.rst_host_out, 0);
      chk("arst_mode", bus.mode, 0);
      chk("arst_region", bus.region_out, 0);
      chk("arst_leds", {bus.led_ntsc, bus.led_pal}, 0);
      m_mode = 0;
      @(negedge clk);
      rst = 1'b1;
      step(2);
      chk("arst_run_reg", bus.region_out, ref_region(0, bus.cic_region));
      chk("arst_run_host", bus.rst_host_out, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
